// File: rtl/ebr_readback_pkg.sv
// ebr_readback_pkg
//   Shared types and helpers for the EBR read-back sweep engine.
//   - state_e            : sweep controller states
//   - calc_read_latency  : EBR read latency in cycles for a given OUTREG setting
package ebr_readback_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // The EBR always takes one cycle from address to data; the optional
    // output register adds one more.
    function automatic int calc_read_latency(input int outreg);
        return (outreg != 0) ? 2 : 1;
    endfunction

endpackage

// File: rtl/ebr_rb_fifo.sv
// ebr_rb_fifo
//   Small circular FIFO holding words returned from the EBR until the stream
//   sink accepts them. The head word is presented from storage, so it stays
//   stable while the consumer stalls.
//   Ports:
//     clk, rst     clock, synchronous active-high reset (clears pointers/count)
//     push_i       write data_i this cycle (caller guarantees not full)
//     data_i       word to store
//     pop_i        drop the head word this cycle (caller guarantees not empty)
//     data_o       head word
//     empty_o      FIFO holds no words
//     count_o      number of words held
module ebr_rb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: clocked state is written with <= so every register samples the
    // pre-edge values of its neighbours, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_next(rd_ptr_q);
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // NOTE: storage has no reset; stale contents are unreachable once the
    // count is cleared, and leaving it out keeps this a plain register file.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/ebr_readback.sv
// ebr_readback
//   Sweeps a contiguous (wrapping) range of EBR words and streams them out
//   with their addresses. Reads are issued only when the output FIFO has
//   room for every word already in flight, so nothing is ever dropped.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     start                begin a sweep (ignored while busy)
//     base_addr, length    first address / word count, sampled on accepted start
//     busy, done           sweep in progress / one-cycle completion pulse
//     ebr_ce, ebr_addr     EBR read enable and address
//     ebr_dout             EBR read data, valid RL cycles after ebr_ce
//     m_valid, m_ready     output stream handshake
//     m_data, m_addr       returned word and the address it came from
//     m_last               final word of the sweep
module ebr_readback
    import ebr_readback_pkg::*;
#(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 10,
    parameter int OUTREG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              ebr_ce,
    output logic [ADDR_W-1:0] ebr_addr,
    input  logic [DATA_W-1:0] ebr_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_last
);

    localparam int RL     = calc_read_latency(OUTREG);
    localparam int DEPTH  = RL + 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int FIFO_W = DATA_W + ADDR_W + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic              done_q, done_d;

    // Read-return pipeline: one slot per cycle of EBR latency, tagging each
    // returning word with its address and last-word flag.
    logic [RL-1:0]     pipe_vld_q;
    logic [RL-1:0]     pipe_last_q;
    logic [ADDR_W-1:0] pipe_addr_q [RL];

    logic              issue;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   cur_rem;
    logic              credit_ok;
    int                credit;
    logic              pop;
    logic              landing;

    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_empty;
    logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;
    logic              fifo_last;

    assign landing = pipe_vld_q[RL-1];
    assign m_valid = !fifo_empty;
    assign pop     = m_valid & m_ready;

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        issue    = 1'b0;
        cur_addr = addr_q;
        cur_rem  = rem_q;
        // A slot freed by this cycle's pop is usable: the new read cannot land
        // before that pop has taken effect.
        credit    = DEPTH - int'(fifo_cnt) + int'(pop) - int'(inflight_q);
        credit_ok = (credit > 0) && !rst;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cur_addr = base_addr;
                    cur_rem  = length;
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        issue   = credit_ok;
                    end
                end
            end
            RUN: begin
                issue = credit_ok && (rem_q != '0);
                if ((rem_q == '0) || (issue && rem_q == (ADDR_W+1)'(1)))
                    state_d = DRAIN;
            end
            DRAIN: ;
            default: state_d = IDLE;
        endcase

        // Accepting a start always loads the sweep registers, even when the
        // first read has to wait for credit.
        if (issue) begin
            addr_d = cur_addr + ADDR_W'(1);
            rem_d  = cur_rem - (ADDR_W+1)'(1);
        end else if (state_q == IDLE && start) begin
            addr_d = cur_addr;
            rem_d  = cur_rem;
        end

        if (state_q != IDLE && pop && fifo_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end

        hold_addr_d = issue ? cur_addr : hold_addr_q;
        inflight_d  = inflight_q + CNT_W'(issue) - CNT_W'(landing);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            hold_addr_q <= '0;
            inflight_q  <= '0;
            done_q      <= 1'b0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            rem_q          <= rem_d;
            hold_addr_q    <= hold_addr_d;
            inflight_q     <= inflight_d;
            done_q         <= done_d;
            pipe_vld_q[0]  <= issue;
            pipe_last_q[0] <= (cur_rem == (ADDR_W+1)'(1));
            for (int k = 1; k < RL; k++) begin
                pipe_vld_q[k]  <= pipe_vld_q[k-1];
                pipe_last_q[k] <= pipe_last_q[k-1];
            end
        end
    end

    // Address tags only matter alongside a valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        pipe_addr_q[0] <= cur_addr;
        for (int k = 1; k < RL; k++) pipe_addr_q[k] <= pipe_addr_q[k-1];
    end

    assign fifo_wdata = {pipe_last_q[RL-1], pipe_addr_q[RL-1], ebr_dout};

    ebr_rb_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (landing),
        .data_i  (fifo_wdata),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign {fifo_last, m_addr, m_data} = fifo_rdata;
    assign m_last   = m_valid & fifo_last;
    assign ebr_ce   = issue;
    assign ebr_addr = issue ? cur_addr : hold_addr_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_ebr_readback.sv
// tb_ebr_readback
//   Directed bench for ebr_readback: one instance with OUTREG=0 (index 0) and
//   one with OUTREG=1 (index 1), each fed by a behavioural EBR model whose
//   word at address a is {a[7:0]^8'h5A, a}.
module tb_ebr_readback;

    localparam int DW = 18;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    start, busy, done, ebr_ce, m_valid, m_ready, m_last;
    logic [AW-1:0] base_addr [2];
    logic [AW:0]   length    [2];
    logic [AW-1:0] ebr_addr  [2];
    logic [AW-1:0] m_addr    [2];
    logic [DW-1:0] ebr_dout  [2];
    logic [DW-1:0] m_data    [2];
    logic [DW-1:0] st1 [2];
    logic [DW-1:0] st2 [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ebr_word(input logic [AW-1:0] a);
        return {a[7:0] ^ 8'h5A, a};
    endfunction

    // EBR models: instance 0 returns data one cycle after ce, instance 1 two.
    always @(posedge clk) begin
        if (ebr_ce[0]) st1[0] <= ebr_word(ebr_addr[0]);
        if (ebr_ce[1]) st1[1] <= ebr_word(ebr_addr[1]);
        st2[1] <= st1[1];
    end
    assign st2[0]      = '0;
    assign ebr_dout[0] = st1[0];
    assign ebr_dout[1] = st2[1];

    ebr_readback #(.DATA_W(DW), .ADDR_W(AW), .OUTREG(0)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .base_addr(base_addr[0]),
        .length(length[0]), .busy(busy[0]), .done(done[0]), .ebr_ce(ebr_ce[0]),
        .ebr_addr(ebr_addr[0]), .ebr_dout(ebr_dout[0]), .m_valid(m_valid[0]),
        .m_ready(m_ready[0]), .m_data(m_data[0]), .m_addr(m_addr[0]), .m_last(m_last[0])
    );

    ebr_readback #(.DATA_W(DW), .ADDR_W(AW), .OUTREG(1)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .base_addr(base_addr[1]),
        .length(length[1]), .busy(busy[1]), .done(done[1]), .ebr_ce(ebr_ce[1]),
        .ebr_addr(ebr_addr[1]), .ebr_dout(ebr_dout[1]), .m_valid(m_valid[1]),
        .m_ready(m_ready[1]), .m_data(m_data[1]), .m_addr(m_addr[1]), .m_last(m_last[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Results of the most recent sweep (cycle numbers count from the start cycle = 0).
    int r_n, r_first, r_last, r_done, r_ce, r_viol, r_unstable, r_stalls, r_busy;

    task automatic sweep(input int i, input logic [AW-1:0] base, input logic [AW:0] len,
                         input bit toggle, input int restart_at, input int abort_after,
                         input int budget);
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] hd;
        logic [AW-1:0] ha;
        logic          hl;
        bit            prev_stall;
        int            issued;
        r_n = 0; r_first = -1; r_last = -1; r_done = -1; r_ce = 0;
        r_viol = 0; r_unstable = 0; r_stalls = 0; r_busy = 0;
        exp_addr = base; prev_stall = 0; issued = 0; hd = '0; ha = '0; hl = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            start[i] = (c == 0) || (c == restart_at);
            if (restart_at >= 0 && c >= restart_at) begin
                base_addr[i] = 10'h300;
                length[i]    = 11'd2;
            end else begin
                base_addr[i] = base;
                length[i]    = len;
            end
            m_ready[i] = toggle ? (c % 2 == 0) : 1'b1;
            #1;
            if (busy[i]) r_busy++;
            if (prev_stall && (m_valid[i] !== 1'b1 || m_data[i] !== hd ||
                               m_addr[i] !== ha || m_last[i] !== hl)) r_unstable++;
            prev_stall = m_valid[i] && !m_ready[i];
            hd = m_data[i]; ha = m_addr[i]; hl = m_last[i];
            if (ebr_ce[i]) begin
                r_ce++;
                issued++;
            end else if (busy[i] && c > 0 && issued < int'(len)) begin
                r_stalls++;
            end
            if (m_valid[i] && r_first < 0) r_first = c;
            if (m_valid[i] && m_ready[i]) begin
                check($sformatf("i%0d addr[%0d]", i, r_n), m_addr[i], exp_addr);
                check($sformatf("i%0d data[%0d]", i, r_n), m_data[i], ebr_word(exp_addr));
                check($sformatf("i%0d last[%0d]", i, r_n), m_last[i], r_n == int'(len) - 1);
                r_n++;
                r_last = c;
                exp_addr = exp_addr + AW'(1);
            end
            if (issued - r_n > 2 + i) r_viol++;
            if (done[i]) begin
                r_done = c;
                check($sformatf("i%0d busy_at_done", i), busy[i], 0);
                break;
            end
            if (abort_after > 0 && r_n == abort_after) break;
        end
        start[i] = 1'b0;
    endtask

    initial begin
        int stale;
        rst = 1'b1;
        start = '0;
        m_ready = '0;
        for (int i = 0; i < 2; i++) begin
            base_addr[i] = '0;
            length[i]    = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("i%0d rst busy", i),    busy[i],    0);
            check($sformatf("i%0d rst done", i),    done[i],    0);
            check($sformatf("i%0d rst ce", i),      ebr_ce[i],  0);
            check($sformatf("i%0d rst m_valid", i), m_valid[i], 0);
            check($sformatf("i%0d rst m_last", i),  m_last[i],  0);
            check($sformatf("i%0d rst addr", i),    ebr_addr[i], 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Wrapping sweep, RL=1: words in cycles 2..5, done in 6.
        sweep(0, 10'h3FE, 11'd4, 0, -1, 0, 40);
        check("wrap0 count", r_n, 4);
        check("wrap0 first", r_first, 2);
        check("wrap0 last",  r_last, 5);
        check("wrap0 done",  r_done, 6);
        check("wrap0 ce",    r_ce, 4);

        // Same sweep, RL=2: words in cycles 3..6, done in 7.
        sweep(1, 10'h3FE, 11'd4, 0, -1, 0, 40);
        check("wrap1 count", r_n, 4);
        check("wrap1 first", r_first, 3);
        check("wrap1 done",  r_done, 7);

        // Zero-length: done next cycle, nothing else.
        sweep(0, 10'h055, 11'd0, 0, -1, 0, 20);
        check("len0 done",  r_done, 1);
        check("len0 ce",    r_ce, 0);
        check("len0 valid", r_first, -1);
        check("len0 busy",  r_busy, 0);

        // Back-pressure, RL=2: ready toggles, credit must throttle reads.
        sweep(1, 10'h0F8, 11'd16, 1, -1, 0, 200);
        check("bp count",    r_n, 16);
        check("bp ce",       r_ce, 16);
        check("bp first",    r_first, 3);
        check("bp done",     r_done, r_last + 1);
        check("bp overflow", r_viol, 0);
        check("bp stable",   r_unstable, 0);
        check("bp stalled",  r_stalls > 0, 1);

        // Full sweep: 1024 words in 1024 consecutive cycles.
        sweep(0, 10'h000, 11'd1024, 0, -1, 0, 1100);
        check("full count", r_n, 1024);
        check("full first", r_first, 2);
        check("full span",  r_last - r_first, 1023);
        check("full done",  r_done, r_last + 1);
        check("full ce",    r_ce, 1024);

        // Start while busy with a different base/length is ignored.
        sweep(0, 10'h010, 11'd6, 0, 2, 0, 60);
        check("restart count", r_n, 6);
        check("restart done",  r_done, 8);
        check("restart ce",    r_ce, 6);

        // Reset after 3 of 8 words, then a fresh sweep.
        sweep(0, 10'h100, 11'd8, 0, -1, 3, 40);
        check("abort words", r_n, 3);
        @(negedge clk);
        rst = 1'b1;
        m_ready[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort busy",    busy[0],    0);
        check("abort done",    done[0],    0);
        check("abort ce",      ebr_ce[0],  0);
        check("abort m_valid", m_valid[0], 0);
        check("abort m_last",  m_last[0],  0);
        check("abort addr",    ebr_addr[0], 0);
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (m_valid[0] || done[0] || ebr_ce[0] || busy[0]) stale++;
        end
        check("abort stale", stale, 0);
        sweep(0, 10'h200, 11'd3, 0, -1, 0, 40);
        check("post count", r_n, 3);
        check("post first", r_first, 2);
        check("post done",  r_done, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
